// File: rtl/ddr_pkg.sv
// Shared types for the DDR command sequencer: FSM states, command encodings, bus layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ddr_pkg;

   // Default timing, in core clock cycles
   localparam int unsigned TRCD_DEF      = 2;
   localparam int unsigned TRP_DEF       = 2;
   localparam int unsigned TRFC_DEF      = 8;
   localparam int unsigned TAPW_DEF      = 4;
   localparam int unsigned BURST_CYC_DEF = 2;
   localparam int unsigned TREFI_DEF     = 780;

   // Auto-precharge / precharge-all lives in address bit 10
   localparam int unsigned      AP_BIT    = 10;
   localparam logic [12:0]      A_PRE_ALL = 13'(1) << AP_BIT;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACT,
      ST_XFER,
      ST_HOLD,
      ST_APW,
      ST_PREA,
      ST_REF
   } state_e;

   // {ras_n, cas_n, we_n}
   typedef enum logic [2:0] {
      CMD_NOP = 3'b111,
      CMD_ACT = 3'b011,
      CMD_RD  = 3'b101,
      CMD_WR  = 3'b100,
      CMD_PRE = 3'b010,
      CMD_REF = 3'b001
   } ddr_cmd_e;

   typedef struct packed {
      logic        cs_n;
      ddr_cmd_e    cmd;
      logic [1:0]  ba;
      logic [12:0] a;
   } ddr_bus_t;

   localparam ddr_bus_t BUS_RST = '{cs_n: 1'b1, cmd: CMD_NOP, ba: 2'd0, a: 13'd0};

   // Column address: a[10] = auto-precharge, a[8:1] = column, a[0] = 0
   function automatic logic [12:0] col_addr(input logic ap, input logic [7:0] col);
      return {2'b00, ap, 1'b0, col, 1'b0};
   endfunction

endpackage

// File: rtl/ddr_reftimer.sv
// Refresh interval timer with request/ack latch; a second expiry while pending is dropped.
// Latency: req_o rises on the TREFI-th enabled edge; ack latched one edge after it is seen.
// Backpressure: req_o holds until done_i; ack_i is ignored unless req_o is set.
//
// Ports: clock_i, reset_ni (async active-low), enable_i (timer runs only when high),
//        ack_i (scheduler grant), done_i (refresh finished, clears req/ack),
//        req_o (refresh requested), ack_o (grant latched, pending service).
module ddr_reftimer #(
   parameter int unsigned TREFI = 780
) (
   input  logic clock_i,
   input  logic reset_ni,
   input  logic enable_i,
   input  logic ack_i,
   input  logic done_i,
   output logic req_o,
   output logic ack_o
);

   localparam logic [9:0] RELOAD = 10'(TREFI - 1);

   logic [9:0] cnt_q;

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q <= RELOAD;
         req_o <= 1'b0;
         ack_o <= 1'b0;
      end else begin
         if (enable_i) begin
            if (cnt_q == 10'd0) cnt_q <= RELOAD;
            else                cnt_q <= cnt_q - 10'd1;
         end
         if (done_i) begin
            req_o <= 1'b0;
            ack_o <= 1'b0;
         end else begin
            // Setting an already-set req is how a second expiry gets dropped
            if (enable_i && cnt_q == 10'd0) req_o <= 1'b1;
            if (req_o && ack_i)             ack_o <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ddr_cmdseq.sv
// DDR SDRAM command sequencer: ACTIVE / READ / WRITE-AP / PRECHARGE-all / AUTO REFRESH.
// Latency: every bus output is registered; a command decided at edge k is on the bus in cycle k+1.
// Backpressure: cmd_start_i only taken in IDLE; cmd_susp_i stalls column commands with the row open.
//
// Ports: clock_i/reset_ni; enable_i (init done); cmd_* scheduler command interface;
//        ctl_* one-cycle strobes per issued command; rfc_req_o/rfc_ack_i/rfc_end_o refresh
//        handshake; ddr_* registered DDR command/address bus.
module ddr_cmdseq
   import ddr_pkg::*;
#(
   parameter int unsigned TRCD      = TRCD_DEF,
   parameter int unsigned TRP       = TRP_DEF,
   parameter int unsigned TRFC      = TRFC_DEF,
   parameter int unsigned TAPW      = TAPW_DEF,
   parameter int unsigned BURST_CYC = BURST_CYC_DEF,
   parameter int unsigned TREFI     = TREFI_DEF
) (
   input  logic        clock_i,
   input  logic        reset_ni,
   input  logic        enable_i,
   input  logic        cmd_start_i,
   input  logic        cmd_read_i,
   input  logic        cmd_last_i,
   input  logic        cmd_susp_i,
   input  logic [1:0]  cmd_bank_i,
   input  logic [12:0] cmd_row_i,
   input  logic [7:0]  cmd_col_i,
   output logic        ctl_read_o,
   output logic        ctl_write_o,
   output logic        ctl_active_o,
   output logic        rfc_req_o,
   input  logic        rfc_ack_i,
   output logic        rfc_end_o,
   output logic        ddr_cs_no,
   output logic        ddr_ras_no,
   output logic        ddr_cas_no,
   output logic        ddr_we_no,
   output logic [1:0]  ddr_ba_o,
   output logic [12:0] ddr_a_o
);

   // Wait-count reload values. States that hand over to a state which then issues the
   // next command load T-2; states that issue the next command themselves on expiry
   // (XFER burst gap, PREA, REF) load T-1. Either way the next command lands T cycles
   // after the previous one. Timings below 2 are not supported.
   localparam logic [3:0] LD_TRCD  = 4'(TRCD - 2);
   localparam logic [3:0] LD_TAPW  = 4'(TAPW - 2);
   localparam logic [3:0] LD_BURST = 4'(BURST_CYC - 1);
   localparam logic [3:0] LD_TRP   = 4'(TRP - 1);
   localparam logic [3:0] LD_TRFC  = 4'(TRFC - 1);

   state_e     state_q, state_d;
   logic [3:0] wcnt_q, wcnt_d;
   logic       rd_q, rd_d;
   logic [1:0] bank_q, bank_d;
   logic [7:0] col_q, col_d;
   ddr_bus_t   bus_q, bus_d;
   logic       ctl_read_d, ctl_write_d, ctl_active_d;
   logic       rfc_done;
   logic       ack_lat;

   ddr_reftimer #(.TREFI(TREFI)) u_reftimer (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .enable_i (enable_i),
      .ack_i    (rfc_ack_i),
      .done_i   (rfc_done),
      .req_o    (rfc_req_o),
      .ack_o    (ack_lat)
   );

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q      <= ST_IDLE;
         wcnt_q       <= 4'd0;
         rd_q         <= 1'b0;
         bank_q       <= 2'd0;
         col_q        <= 8'd0;
         bus_q        <= BUS_RST;
         ctl_read_o   <= 1'b0;
         ctl_write_o  <= 1'b0;
         ctl_active_o <= 1'b0;
         rfc_end_o    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wcnt_q       <= wcnt_d;
         rd_q         <= rd_d;
         bank_q       <= bank_d;
         col_q        <= col_d;
         bus_q        <= bus_d;
         ctl_read_o   <= ctl_read_d;
         ctl_write_o  <= ctl_write_d;
         ctl_active_o <= ctl_active_d;
         rfc_end_o    <= rfc_done;
      end
   end

   always_comb begin
      state_d      = state_q;
      wcnt_d       = wcnt_q;
      rd_d         = rd_q;
      bank_d       = bank_q;
      col_d        = col_q;
      bus_d        = bus_q;
      bus_d.cmd    = CMD_NOP;
      ctl_read_d   = 1'b0;
      ctl_write_d  = 1'b0;
      ctl_active_d = 1'b0;
      rfc_done     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // A latched refresh grant beats a start in the same cycle
            if (ack_lat) begin
               bus_d.cmd = CMD_PRE;
               bus_d.a   = A_PRE_ALL;
               wcnt_d    = LD_TRP;
               state_d   = ST_PREA;
            end else if (cmd_start_i && enable_i) begin
               // Row goes straight onto the bus, so it is never stored
               rd_d         = cmd_read_i;
               bank_d       = cmd_bank_i;
               col_d        = cmd_col_i;
               bus_d.cmd    = CMD_ACT;
               bus_d.ba     = cmd_bank_i;
               bus_d.a      = cmd_row_i;
               ctl_active_d = 1'b1;
               wcnt_d       = LD_TRCD;
               state_d      = ST_ACT;
            end
         end
         ST_ACT: begin
            if (wcnt_q == 4'd0) state_d = ST_XFER;
            else                wcnt_d  = wcnt_q - 4'd1;
         end
         ST_XFER: begin
            if (wcnt_q != 4'd0) begin
               wcnt_d = wcnt_q - 4'd1;
            end else if (cmd_susp_i) begin
               // Suspend wins over last; last is looked at again on resume
               state_d = ST_HOLD;
            end else begin
               bus_d.cmd   = rd_q ? CMD_RD : CMD_WR;
               bus_d.ba    = bank_q;
               bus_d.a     = col_addr(cmd_last_i, col_q);
               ctl_read_d  = rd_q;
               ctl_write_d = !rd_q;
               col_d       = col_q + 8'd2;
               if (cmd_last_i) begin
                  wcnt_d  = LD_TAPW;
                  state_d = ST_APW;
               end else begin
                  wcnt_d  = LD_BURST;
               end
            end
         end
         ST_HOLD: begin
            if (!cmd_susp_i) state_d = ST_XFER;
         end
         ST_APW: begin
            if (wcnt_q == 4'd0) state_d = ST_IDLE;
            else                wcnt_d  = wcnt_q - 4'd1;
         end
         ST_PREA: begin
            if (wcnt_q == 4'd0) begin
               bus_d.cmd = CMD_REF;
               wcnt_d    = LD_TRFC;
               state_d   = ST_REF;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         ST_REF: begin
            if (wcnt_q == 4'd0) begin
               rfc_done = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Idle cycles are NOP when enabled, deselect before init completes
      bus_d.cs_n = (bus_d.cmd == CMD_NOP) ? !enable_i : 1'b0;
   end

   assign ddr_cs_no  = bus_q.cs_n;
   assign ddr_ras_no = bus_q.cmd[2];
   assign ddr_cas_no = bus_q.cmd[1];
   assign ddr_we_no  = bus_q.cmd[0];
   assign ddr_ba_o   = bus_q.ba;
   assign ddr_a_o    = bus_q.a;

endmodule

// File: tb/tb_ddr_cmdseq.sv
// Directed bench for ddr_cmdseq with TREFI shortened to 16.
// Latency: inputs change 1 ns after a rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_ddr_cmdseq;

   localparam logic [3:0] B_DES = 4'b1111;
   localparam logic [3:0] B_NOP = 4'b0111;
   localparam logic [3:0] B_ACT = 4'b0011;
   localparam logic [3:0] B_RD  = 4'b0101;
   localparam logic [3:0] B_WR  = 4'b0100;
   localparam logic [3:0] B_PRE = 4'b0010;
   localparam logic [3:0] B_REF = 4'b0001;

   logic        clock_i = 1'b0;
   logic        reset_ni;
   logic        enable_i, cmd_start_i, cmd_read_i, cmd_last_i, cmd_susp_i, rfc_ack_i;
   logic [1:0]  cmd_bank_i;
   logic [12:0] cmd_row_i;
   logic [7:0]  cmd_col_i;
   logic        ctl_read_o, ctl_write_o, ctl_active_o, rfc_req_o, rfc_end_o;
   logic        ddr_cs_no, ddr_ras_no, ddr_cas_no, ddr_we_no;
   logic [1:0]  ddr_ba_o;
   logic [12:0] ddr_a_o;

   int n_cmp = 0;
   int n_bad = 0;
   int n_rd  = 0;
   int n_wr  = 0;
   int n_act = 0;

   always #5 clock_i = ~clock_i;

   ddr_cmdseq #(.TREFI(16)) dut (
      .clock_i      (clock_i),
      .reset_ni     (reset_ni),
      .enable_i     (enable_i),
      .cmd_start_i  (cmd_start_i),
      .cmd_read_i   (cmd_read_i),
      .cmd_last_i   (cmd_last_i),
      .cmd_susp_i   (cmd_susp_i),
      .cmd_bank_i   (cmd_bank_i),
      .cmd_row_i    (cmd_row_i),
      .cmd_col_i    (cmd_col_i),
      .ctl_read_o   (ctl_read_o),
      .ctl_write_o  (ctl_write_o),
      .ctl_active_o (ctl_active_o),
      .rfc_req_o    (rfc_req_o),
      .rfc_ack_i    (rfc_ack_i),
      .rfc_end_o    (rfc_end_o),
      .ddr_cs_no    (ddr_cs_no),
      .ddr_ras_no   (ddr_ras_no),
      .ddr_cas_no   (ddr_cas_no),
      .ddr_we_no    (ddr_we_no),
      .ddr_ba_o     (ddr_ba_o),
      .ddr_a_o      (ddr_a_o)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic [3:0] exp);
      check({tag, ".cmd"}, 16'({ddr_cs_no, ddr_ras_no, ddr_cas_no, ddr_we_no}), 16'(exp));
   endtask

   task automatic chk_cmd(input string tag, input logic [3:0] exp,
                          input logic [1:0] ba, input logic [12:0] a);
      chk_bus(tag, exp);
      check({tag, ".ba"}, 16'(ddr_ba_o), 16'(ba));
      check({tag, ".a"},  16'(ddr_a_o),  16'(a));
   endtask

   task automatic step();
      @(posedge clock_i);
      #1;
      if (ctl_read_o)   n_rd++;
      if (ctl_write_o)  n_wr++;
      if (ctl_active_o) n_act++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_req(input string tag);
      int k;
      k = 0;
      while (!rfc_req_o && k < 64) begin
         step();
         k++;
      end
      check(tag, 16'(rfc_req_o), 16'd1);
   endtask

   task automatic set_cmd(input logic rd, input logic last, input logic [1:0] bank,
                          input logic [12:0] row, input logic [7:0] col);
      cmd_start_i = 1'b1;
      cmd_read_i  = rd;
      cmd_last_i  = last;
      cmd_bank_i  = bank;
      cmd_row_i   = row;
      cmd_col_i   = col;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_ni = 1'b1;
      enable_i = 1'b0; cmd_start_i = 1'b0; cmd_read_i = 1'b0; cmd_last_i = 1'b0;
      cmd_susp_i = 1'b0; rfc_ack_i = 1'b0;
      cmd_bank_i = '0; cmd_row_i = '0; cmd_col_i = '0;
      #1 reset_ni = 1'b0;
      #3;
      // Reset state
      chk_cmd("rst", B_DES, 2'd0, 13'd0);
      check("rst.ctl", 16'({ctl_read_o, ctl_write_o, ctl_active_o}), 16'd0);
      check("rst.req", 16'(rfc_req_o), 16'd0);
      check("rst.end", 16'(rfc_end_o), 16'd0);
      steps(2);
      reset_ni = 1'b1;
      step();
      chk_bus("disabled", B_DES);

      // Refresh request after 16 enabled edges
      enable_i = 1'b1;
      steps(15);
      check("req.early", 16'(rfc_req_o), 16'd0);
      chk_bus("idle.nop", B_NOP);
      step();
      check("req.rise", 16'(rfc_req_o), 16'd1);

      // Ack while idle: PRE, REF after TRP, end TRFC after REF
      rfc_ack_i = 1'b1;
      step();
      rfc_ack_i = 1'b0;
      chk_bus("ack.nop", B_NOP);
      step();
      chk_cmd("idle.pre", B_PRE, 2'd0, 13'h400);
      step();
      chk_bus("trp.nop", B_NOP);
      step();
      chk_bus("idle.ref", B_REF);
      steps(7);
      check("trfc.end0", 16'(rfc_end_o), 16'd0);
      check("trfc.req1", 16'(rfc_req_o), 16'd1);
      step();
      check("trfc.end1", 16'(rfc_end_o), 16'd1);
      check("trfc.req0", 16'(rfc_req_o), 16'd0);
      step();
      check("trfc.end_pulse", 16'(rfc_end_o), 16'd0);

      // Single-word read
      n_rd = 0; n_wr = 0; n_act = 0;
      set_cmd(1'b1, 1'b1, 2'd2, 13'h1ABC, 8'h10);
      step();
      chk_cmd("sw.act", B_ACT, 2'd2, 13'h1ABC);
      check("sw.ctl_act", 16'(ctl_active_o), 16'd1);
      cmd_start_i = 1'b0;
      step();
      chk_bus("sw.trcd", B_NOP);
      step();
      chk_cmd("sw.read", B_RD, 2'd2, 13'h420);
      check("sw.ctl_rd", 16'(ctl_read_o), 16'd1);

      // Block write held pending through APW: ACT lands 4 cycles after the READ
      set_cmd(1'b0, 1'b0, 2'd1, 13'h0055, 8'hFC);
      steps(3);
      chk_bus("apw.nop", B_NOP);
      check("sw.n_act", 16'(n_act), 16'd1);
      check("sw.n_rd", 16'(n_rd), 16'd1);
      step();
      chk_cmd("bw.act", B_ACT, 2'd1, 13'h0055);
      cmd_start_i = 1'b0;
      step();
      chk_bus("bw.trcd", B_NOP);
      step();
      chk_cmd("bw.wr0", B_WR, 2'd1, 13'h1F8);
      steps(2);
      chk_cmd("bw.wr1", B_WR, 2'd1, 13'h1FC);
      steps(2);
      chk_cmd("bw.wr2", B_WR, 2'd1, 13'h000);
      step();
      cmd_last_i = 1'b1;
      step();
      chk_cmd("bw.wr3", B_WR, 2'd1, 13'h404);
      check("bw.n_wr", 16'(n_wr), 16'd4);

      // Read block with suspend after the second burst
      n_rd = 0;
      set_cmd(1'b1, 1'b0, 2'd3, 13'h0F0F, 8'h00);
      steps(4);
      chk_cmd("su.act", B_ACT, 2'd3, 13'h0F0F);
      cmd_start_i = 1'b0;
      steps(2);
      chk_cmd("su.rd0", B_RD, 2'd3, 13'h000);
      steps(2);
      chk_cmd("su.rd1", B_RD, 2'd3, 13'h004);
      cmd_susp_i = 1'b1;
      cmd_last_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk_bus("su.hold", B_NOP);
      end
      cmd_susp_i = 1'b0;
      cmd_last_i = 1'b0;
      step();
      chk_bus("su.resume", B_NOP);
      step();
      chk_cmd("su.rd2", B_RD, 2'd3, 13'h008);
      cmd_last_i = 1'b1;
      steps(2);
      chk_cmd("su.rd3", B_RD, 2'd3, 13'h40C);
      check("su.n_rd", 16'(n_rd), 16'd4);
      cmd_last_i = 1'b0;
      steps(4);

      // Ack mid-block: PRE deferred until after APW
      wait_req("mb.req");
      set_cmd(1'b0, 1'b0, 2'd0, 13'h0123, 8'h20);
      step();
      chk_cmd("mb.act", B_ACT, 2'd0, 13'h0123);
      cmd_start_i = 1'b0;
      rfc_ack_i = 1'b1;
      step();
      rfc_ack_i = 1'b0;
      step();
      chk_cmd("mb.wr0", B_WR, 2'd0, 13'h040);
      cmd_last_i = 1'b1;
      steps(2);
      chk_cmd("mb.wr1", B_WR, 2'd0, 13'h444);
      cmd_last_i = 1'b0;
      steps(3);
      chk_bus("mb.apw", B_NOP);
      step();
      chk_cmd("mb.pre", B_PRE, 2'd0, 13'h400);
      steps(2);
      chk_bus("mb.ref", B_REF);
      steps(8);
      check("mb.end", 16'(rfc_end_o), 16'd1);

      // Ack latched and start in the same idle cycle: refresh wins
      wait_req("co.req");
      rfc_ack_i = 1'b1;
      step();
      rfc_ack_i = 1'b0;
      n_act = 0;
      set_cmd(1'b1, 1'b1, 2'd2, 13'h0AAA, 8'h40);
      step();
      chk_bus("co.pre", B_PRE);
      check("co.n_act", 16'(n_act), 16'd0);
      cmd_start_i = 1'b0;
      cmd_last_i  = 1'b0;
      steps(2);
      chk_bus("co.ref", B_REF);
      steps(8);
      check("co.end", 16'(rfc_end_o), 16'd1);

      // Asynchronous reset in the middle of a transfer
      set_cmd(1'b1, 1'b0, 2'd1, 13'h0777, 8'h30);
      step();
      chk_cmd("ar.act", B_ACT, 2'd1, 13'h0777);
      cmd_start_i = 1'b0;
      steps(2);
      chk_cmd("ar.rd", B_RD, 2'd1, 13'h060);
      #2 reset_ni = 1'b0;
      #1;
      chk_cmd("ar.async", B_DES, 2'd0, 13'd0);
      check("ar.ctl", 16'({ctl_read_o, ctl_write_o, ctl_active_o}), 16'd0);
      check("ar.req", 16'(rfc_req_o), 16'd0);
      #2 reset_ni = 1'b1;
      steps(2);
      chk_bus("ar.idle", B_NOP);
      set_cmd(1'b1, 1'b1, 2'd3, 13'h0001, 8'h00);
      step();
      chk_cmd("ar.restart", B_ACT, 2'd3, 13'h0001);
      cmd_start_i = 1'b0;
      cmd_last_i  = 1'b0;
      steps(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
